// File: rtl/engine2vga_writer_pkg.sv
// Shared constants and state encoding for the frame buffer write front end.
package engine2vga_writer_pkg;

  localparam int unsigned DEF_H_RES      = 640;
  localparam int unsigned DEF_V_RES      = 480;
  localparam int unsigned FRAME_PIXELS   = DEF_H_RES * DEF_V_RES;
  localparam int unsigned ADDR_W         = 19;
  localparam int unsigned PIX_W          = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam logic [PIX_W-1:0] DEF_CLEAR_VAL = 8'd254;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/engine2vga_writer_if.sv
// Engine-side handshake, control strobes and frame buffer write port.
interface engine2vga_writer_if;
  import engine2vga_writer_pkg::*;

  logic              start;
  logic              clear;
  logic              abort;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  data;
  logic              wr_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, clear, abort, pix_valid, pix_data,
    input  pix_ready, addr, data, wr_en, busy, frame_done
  );

  modport slave (
    input  start, clear, abort, pix_valid, pix_data,
    output pix_ready, addr, data, wr_en, busy, frame_done
  );

endinterface

// File: rtl/engine2vga_writer_pix_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; DEPTH must be a power of two.
module engine2vga_writer_pix_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/engine2vga_writer.sv
// Accepts engine pixels, buffers them, and drives the frame buffer write port
// with an optional clear pass before the frame.
module engine2vga_writer
  import engine2vga_writer_pkg::*;
#(
  parameter int unsigned      H_RES      = DEF_H_RES,
  parameter int unsigned      V_RES      = DEF_V_RES,
  parameter int unsigned      FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [PIX_W-1:0] CLEAR_VAL  = DEF_CLEAR_VAL
) (
  input logic               clk,
  input logic               rst,
  engine2vga_writer_if.slave bus
);

  localparam int unsigned       FramePix  = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FrameEnd  = ADDR_W'(FramePix);
  localparam logic [ADDR_W-1:0] FrameLast = ADDR_W'(FramePix - 1);
  localparam int unsigned       CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0]   FifoFull  = CntW'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d, wr_cnt_q, wr_cnt_d, addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d, pop_data_q, pop_data_d;
  logic              pop_vld_q, pop_vld_d, wr_en_q, wr_en_d, ready_q, ready_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              active, abort_hit, push, pop, flush, fifo_full, fifo_empty;
  logic [PIX_W-1:0]  fifo_dout;
  logic [CntW-1:0]   fifo_cnt, fifo_cnt_nxt;

  engine2vga_writer_pix_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PIX_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (bus.pix_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .cnt  (fifo_cnt)
  );

  always_comb begin
    active    = (state_q == StClear) || (state_q == StRun);
    abort_hit = bus.abort && active;
    push      = bus.pix_valid && ready_q && !abort_hit && !fifo_full;
    pop       = (state_q == StRun) && !fifo_empty && !abort_hit;
    flush     = abort_hit || ((state_q == StIdle) && bus.start);

    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q + ADDR_W'(push);
    wr_cnt_d   = wr_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    pop_vld_d  = pop;
    pop_data_d = pop ? fifo_dout : pop_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = bus.clear ? StClear : StRun;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      StClear: begin
        wr_en_d = 1'b1;
        data_d  = CLEAR_VAL;
        addr_d  = wr_cnt_q;
        if (wr_cnt_q == FrameLast) begin
          state_d  = StRun;
          wr_cnt_d = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
      end
      StRun: begin
        // Popped entry reaches the write port one cycle after its pop.
        if (pop_vld_q) begin
          wr_en_d  = 1'b1;
          data_d   = pop_data_q;
          addr_d   = wr_cnt_q;
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
        if (wr_cnt_q == FrameEnd) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort_hit) begin
      state_d   = StIdle;
      wr_en_d   = 1'b0;
      pop_vld_d = 1'b0;
    end

    // Ready looks at next-state occupancy so a registered ready never overflows.
    fifo_cnt_nxt = flush ? '0 : fifo_cnt + CntW'(push) - CntW'(pop);
    ready_d = ((state_d == StClear) || (state_d == StRun)) &&
              (fifo_cnt_nxt != FifoFull) && (acc_cnt_d < FrameEnd);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      pop_data_q <= '0;
      pop_vld_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      pop_data_q <= pop_data_d;
      pop_vld_q  <= pop_vld_d;
      wr_en_q    <= wr_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.pix_ready  = ready_q;
  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_engine2vga_writer.sv
// Directed bench for engine2vga_writer on a reduced 16x4 frame.
module tb_engine2vga_writer;
  import engine2vga_writer_pkg::*;

  localparam int unsigned H = 16;
  localparam int unsigned V = 4;
  localparam int unsigned FP = H * V;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  engine2vga_writer_if bus ();

  engine2vga_writer #(
    .H_RES     (H),
    .V_RES     (V),
    .FIFO_DEPTH(DEPTH),
    .CLEAR_VAL (8'd254)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic clr);
    bus.start = 1'b1;
    bus.clear = clr;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.clear = 1'b0; bus.abort = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pix_ready, bus.addr, bus.data, bus.wr_en, bus.busy, bus.frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b addr=%0d data=%0d we=%b busy=%b done=%b want all 0",
               bus.pix_ready, bus.addr, bus.data, bus.wr_en, bus.busy, bus.frame_done);
    end
    rst = 1'b0;
    pulse_abort();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.wr_en, bus.pix_ready, bus.frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_abort busy=%b we=%b rdy=%b done=%b want 0000",
               bus.busy, bus.wr_en, bus.pix_ready, bus.frame_done);
    end
  endtask

  task automatic test_clear_pass();
    pulse_start(1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL clear_start busy=%b we=%b want busy=1 we=0", bus.busy, bus.wr_en);
    end
    for (int i = 0; i < int'(FP); i++) begin
      @(negedge clk);
      checks++;
      if (bus.wr_en !== 1'b1 || bus.data !== 8'd254 || bus.addr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL clear_write[%0d] we=%b data=%0d addr=%0d want 1/254/%0d",
                 i, bus.wr_en, bus.data, bus.addr, i);
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.busy, bus.pix_ready} !== 3'b011) begin
        errors++;
        $display("FAIL run_stall we=%b busy=%b rdy=%b want 0/1/1", bus.wr_en, bus.busy, bus.pix_ready);
      end
    end
    pulse_abort();
    checks++;
    if ({bus.busy, bus.wr_en, bus.pix_ready} !== 3'b000) begin
      errors++;
      $display("FAIL stall_abort busy=%b we=%b rdy=%b want 000", bus.busy, bus.wr_en, bus.pix_ready);
    end
  endtask

  task automatic test_full_frame();
    int idx = 0;
    int wr = 0;
    int n = 0;
    bit acc;
    pulse_start(1'b0);
    bus.pix_valid = 1'b1;
    bus.pix_data = 8'd0;
    while (wr < int'(FP) && n < int'(FP) + 50) begin
      acc = bus.pix_valid && bus.pix_ready;
      @(negedge clk);
      n++;
      if (acc) begin
        idx++;
        bus.pix_data = 8'(idx);
      end
      if (wr > 0) begin
        checks++;
        if ({bus.wr_en, bus.frame_done} !== 2'b10) begin
          errors++;
          $display("FAIL stream_gap after %0d writes we=%b done=%b want 1/0", wr, bus.wr_en,
                   bus.frame_done);
        end
      end
      if (bus.wr_en === 1'b1) begin
        if (wr == 0) begin
          checks++;
          if (n != 3) begin
            errors++;
            $display("FAIL first_write_latency got %0d cycles want 3", n);
          end
        end
        checks++;
        if (bus.addr !== ADDR_W'(wr) || bus.data !== 8'(wr)) begin
          errors++;
          $display("FAIL stream_write addr=%0d data=%0d want %0d/%0d", bus.addr, bus.data, wr,
                   wr % 256);
        end
        wr++;
      end
    end
    checks++;
    if (wr != int'(FP)) begin
      errors++;
      $display("FAIL stream_timeout writes=%0d want %0d", wr, FP);
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_done, bus.busy, bus.wr_en, bus.pix_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL frame_done_pulse done=%b busy=%b we=%b rdy=%b want 1100",
               bus.frame_done, bus.busy, bus.wr_en, bus.pix_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL frame_end done=%b busy=%b want 00", bus.frame_done, bus.busy);
    end
    checks++;
    if (idx != int'(FP)) begin
      errors++;
      $display("FAIL accept_count got %0d want %0d", idx, FP);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_random_gaps();
    logic [7:0] q[$];
    int idx = 0;
    int wr = 0;
    int n = 0;
    int dones = 0;
    bit acc;
    pulse_start(1'b0);
    while (wr < int'(FP) && n < 2000) begin
      bus.pix_valid = ($urandom_range(0, 3) != 0);
      bus.pix_data = bus.pix_valid ? 8'(idx * 37 + 5) : 8'($urandom);
      acc = bus.pix_valid && bus.pix_ready;
      if (acc) q.push_back(bus.pix_data);
      @(negedge clk);
      n++;
      if (acc) idx++;
      if (idx == int'(FP)) begin
        checks++;
        if (bus.pix_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_cap rdy=%b want 0", bus.pix_ready);
        end
      end
      if (bus.frame_done === 1'b1) dones++;
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (q.size() == 0 || bus.addr !== ADDR_W'(wr) || bus.data !== q[0]) begin
          errors++;
          $display("FAIL gap_write[%0d] addr=%0d data=%0d want addr %0d data %0d", wr, bus.addr,
                   bus.data, wr, (q.size() != 0) ? int'(q[0]) : -1);
        end
        if (q.size() != 0) void'(q.pop_front());
        wr++;
      end
    end
    bus.pix_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || bus.busy !== 1'b0 || wr != int'(FP)) begin
      errors++;
      $display("FAIL gap_frame_end dones=%0d busy=%b writes=%0d want 1/0/%0d", dones, bus.busy,
               wr, FP);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_clear_fill();
    int idx = 0;
    int wr = 0;
    int n = 0;
    int k;
    logic [7:0] expd;
    bit acc;
    pulse_start(1'b1);
    bus.pix_valid = 1'b1;
    bus.pix_data = 8'd100;
    while (wr < 2 * int'(FP) && n < 400) begin
      acc = bus.pix_valid && bus.pix_ready;
      @(negedge clk);
      n++;
      if (acc) begin
        idx++;
        bus.pix_data = 8'(idx + 100);
        if (idx == int'(DEPTH)) begin
          checks++;
          if (bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_fill rdy=%b want 0", bus.pix_ready);
          end
        end
      end
      if (bus.wr_en === 1'b1) begin
        k = wr % int'(FP);
        expd = (wr < int'(FP)) ? 8'd254 : 8'(k + 100);
        checks++;
        if (bus.addr !== ADDR_W'(k) || bus.data !== expd) begin
          errors++;
          $display("FAIL fill_write[%0d] addr=%0d data=%0d want %0d/%0d", wr, bus.addr, bus.data,
                   k, expd);
        end
        if (wr == int'(FP) - 1) begin
          checks++;
          if (idx != int'(DEPTH)) begin
            errors++;
            $display("FAIL fill_accepts during clear got %0d want %0d", idx, DEPTH);
          end
        end
        wr++;
      end
    end
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr != 2 * int'(FP) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_end writes=%0d busy=%b want %0d/0", wr, bus.busy, 2 * FP);
    end
  endtask

  task automatic test_abort_restart();
    int idx = 0;
    int wr = 0;
    int n = 0;
    bit acc;
    bit hit = 1'b0;
    pulse_start(1'b0);
    bus.pix_valid = 1'b1;
    bus.pix_data = 8'd0;
    while (!hit && n < 200) begin
      acc = bus.pix_valid && bus.pix_ready;
      @(negedge clk);
      n++;
      if (acc) begin
        idx++;
        bus.pix_data = 8'(idx);
      end
      if (bus.wr_en === 1'b1 && bus.addr === ADDR_W'(20)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_target write to 20 not seen");
    end
    pulse_abort();
    checks++;
    if ({bus.busy, bus.wr_en, bus.pix_ready, bus.frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle busy=%b we=%b rdy=%b done=%b want 0000", bus.busy, bus.wr_en,
               bus.pix_ready, bus.frame_done);
    end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.frame_done, bus.busy} !== 3'b000) begin
        errors++;
        $display("FAIL abort_quiet we=%b done=%b busy=%b want 000", bus.wr_en, bus.frame_done,
                 bus.busy);
      end
    end
    idx = 0;
    n = 0;
    bus.pix_data = 8'd200;
    pulse_start(1'b0);
    while (wr < 30 && n < 200) begin
      acc = bus.pix_valid && bus.pix_ready;
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (acc) begin
        idx++;
        bus.pix_data = 8'(idx + 200);
      end
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (bus.addr !== ADDR_W'(wr) || bus.data !== 8'(wr + 200)) begin
          errors++;
          $display("FAIL restart_write[%0d] addr=%0d data=%0d want %0d/%0d", wr, bus.addr,
                   bus.data, wr, (wr + 200) % 256);
        end
        wr++;
        if (wr == 10) bus.start = 1'b1;
      end
    end
    checks++;
    if (bus.busy !== 1'b1 || wr != 30) begin
      errors++;
      $display("FAIL restart_progress busy=%b writes=%0d want 1/30", bus.busy, wr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.pix_ready, bus.addr, bus.data, bus.wr_en, bus.busy, bus.frame_done} !== '0) begin
      errors++;
      $display("FAIL async_reset rdy=%b addr=%0d data=%0d we=%b busy=%b done=%b want all 0",
               bus.pix_ready, bus.addr, bus.data, bus.wr_en, bus.busy, bus.frame_done);
    end
    bus.pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clear_pass();
    test_full_frame();
    test_random_gaps();
    test_clear_fill();
    test_abort_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
